stall_ctrl: RTL and testbench

- Central pipeline hazard controller; produces the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Merges three hazard sources:
  - ID load-use requests.
  - MEM-stage accesses to the shared instruction/data RAM (structural hazard).
  - Multi-cycle EX operations, which this block sequences with its own counter.
- Also keeps a saturating stall-cycle performance counter.

---
 rtl/stall_ctrl_pkg.sv | 21 ++
 rtl/stall_ctrl_sat_counter.sv | 35 +++
 rtl/stall_ctrl.sv | 104 ++++++++++
 tb/tb_stall_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall masks, bus width
// and the EX sequencing FSM states.
package stall_ctrl_pkg;

    localparam int unsigned STALL_W = 6;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Nested masks: each deeper hazard also freezes every earlier stage.
    localparam logic [STALL_W-1:0] STALL_MEM_MASK = {{4{NOSTOP}}, {2{STOP}}};
    localparam logic [STALL_W-1:0] STALL_ID_MASK  = {{3{NOSTOP}}, {3{STOP}}};
    localparam logic [STALL_W-1:0] STALL_EX_MASK  = {{2{NOSTOP}}, {4{STOP}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EX_WAIT = 2'd1,
        DONE    = 2'd2
    } ex_state_e;

endpackage

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable);
// intended for reuse by any performance counter.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/stall_ctrl.sv
// Central hazard controller: merges MEM structural, ID load-use and multi-cycle
// EX stall requests into one stall vector, and counts stalled cycles.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned PERF_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallReqId_i,
    input  logic               memAccess_i,
    input  logic               exStart_i,
    input  logic [CNT_W-1:0]   exCycles_i,
    input  logic               perfClr_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               exBusy_o,
    output logic               exDone_o,
    output logic [PERF_W-1:0]  stallCycles_o
);

    ex_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             ex_accept;
    logic             ex_stall;
    logic [STALL_W-1:0] stall_d;

    assign ex_accept = exStart_i && (exCycles_i != '0) &&
                       ((state_q == IDLE) || (state_q == DONE));
    assign ex_stall  = ex_accept || (state_q == EX_WAIT);

    always_comb begin
        stall_d = '0;
        if (memAccess_i)  stall_d = stall_d | STALL_MEM_MASK;
        if (stallReqId_i) stall_d = stall_d | STALL_ID_MASK;
        if (ex_stall)     stall_d = stall_d | STALL_EX_MASK;
    end

    assign stall_o = rst ? stall_d : '0;

    // cnt_q holds the EX stall cycles still owed, including the current one;
    // leaving EX_WAIT on cnt_q<=1 makes the start cycle count as the first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (ex_accept) begin
                        cnt_q <= exCycles_i - CNT_W'(1);
                        if (exCycles_i > CNT_W'(1)) begin
                            state_q <= EX_WAIT;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                EX_WAIT: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign exBusy_o = busy_q;
    assign exDone_o = done_q;

    sat_counter #(
        .W(PERF_W)
    ) u_perf (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (perfClr_i),
        .en_i  (stall_o != '0),
        .cnt_o (stallCycles_o)
    );

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: expected outputs are queued as each cycle is
// driven and popped for comparison once the DUT outputs have settled.
module tb_stall_ctrl;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PERF_W = 4;

    logic              clk;
    logic              rst;
    logic              stallReqId_i;
    logic              memAccess_i;
    logic              exStart_i;
    logic [CNT_W-1:0]  exCycles_i;
    logic              perfClr_i;
    logic [5:0]        stall_o;
    logic              exBusy_o;
    logic              exDone_o;
    logic [PERF_W-1:0] stallCycles_o;

    typedef struct packed {
        logic [5:0]        stall;
        logic              busy;
        logic              done;
        logic [PERF_W-1:0] perf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic [PERF_W-1:0] exp_perf = '0;

    stall_ctrl #(
        .CNT_W  (CNT_W),
        .PERF_W (PERF_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallReqId_i  (stallReqId_i),
        .memAccess_i   (memAccess_i),
        .exStart_i     (exStart_i),
        .exCycles_i    (exCycles_i),
        .perfClr_i     (perfClr_i),
        .stall_o       (stall_o),
        .exBusy_o      (exBusy_o),
        .exDone_o      (exDone_o),
        .stallCycles_o (stallCycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "timeout");
    end

    task automatic expect_now(input logic [5:0] s, input logic b, input logic d);
        exp_t e;
        e.stall = s;
        e.busy  = b;
        e.done  = d;
        e.perf  = exp_perf;
        exp_q.push_back(e);
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed stall=%h", tag, stall_o);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (stall_o === e.stall) else begin
                errors++;
                $error("FAIL %s stall: observed=%h expected=%h", tag, stall_o, e.stall);
            end
            checks++;
            assert (exBusy_o === e.busy) else begin
                errors++;
                $error("FAIL %s busy: observed=%b expected=%b", tag, exBusy_o, e.busy);
            end
            checks++;
            assert (exDone_o === e.done) else begin
                errors++;
                $error("FAIL %s done: observed=%b expected=%b", tag, exDone_o, e.done);
            end
            checks++;
            assert (stallCycles_o === e.perf) else begin
                errors++;
                $error("FAIL %s perf: observed=%0d expected=%0d", tag, stallCycles_o, e.perf);
            end
        end
    endtask

    // Reference perf counter: reset clears, clear wins, otherwise saturating +1.
    task automatic model_edge(input logic [5:0] s);
        if (!rst)                                  exp_perf = '0;
        else if (perfClr_i)                        exp_perf = '0;
        else if (s != 6'h00 && exp_perf != '1)     exp_perf = exp_perf + 1'b1;
    endtask

    // Called just after a falling edge: drive, queue, compare, advance a cycle.
    task automatic step(input string tag, input logic mem, input logic id,
                        input logic st, input logic [CNT_W-1:0] cyc, input logic clr,
                        input logic [5:0] es, input logic eb, input logic ed);
        memAccess_i  = mem;
        stallReqId_i = id;
        exStart_i    = st;
        exCycles_i   = cyc;
        perfClr_i    = clr;
        expect_now(es, eb, ed);
        #1;
        compare_pop(tag);
        model_edge(es);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        memAccess_i = 1'b0; stallReqId_i = 1'b0; exStart_i = 1'b0;
        exCycles_i = '0; perfClr_i = 1'b0;
        @(negedge clk);

        // Reset held while inputs toggle
        step("rst0", 1, 1, 1, 4'd3, 0, 6'h00, 0, 0);
        step("rst1", 0, 1, 1, 4'd1, 1, 6'h00, 0, 0);
        step("rst2", 1, 0, 0, 4'd7, 0, 6'h00, 0, 0);
        rst = 1'b1;

        // Structural and load-use
        step("mem",    1, 0, 0, 4'd0, 0, 6'h03, 0, 0);
        step("memid",  1, 1, 0, 4'd0, 0, 6'h07, 0, 0);
        step("cnt2",   0, 0, 0, 4'd0, 0, 6'h00, 0, 0);

        // EX op N=3, with an overlapping MEM request in EX_WAIT
        step("ex3_t0", 0, 0, 1, 4'd3, 0, 6'h0F, 0, 0);
        step("ex3_t1", 1, 0, 1, 4'd5, 0, 6'h0F, 1, 0);
        step("ex3_t2", 0, 0, 0, 4'd0, 0, 6'h0F, 1, 0);
        step("ex3_t3", 0, 0, 0, 4'd0, 0, 6'h00, 0, 1);
        step("ex3_t4", 0, 0, 0, 4'd0, 0, 6'h00, 0, 0);

        // N=1, then back-to-back N=2 started in the DONE cycle
        step("ex1_t0", 0, 0, 1, 4'd1, 0, 6'h0F, 0, 0);
        step("b2b_t0", 0, 0, 1, 4'd2, 0, 6'h0F, 0, 1);
        step("b2b_t1", 0, 0, 0, 4'd0, 0, 6'h0F, 1, 0);
        step("b2b_t2", 0, 0, 0, 4'd0, 0, 6'h00, 0, 1);

        // N=0 is a single-cycle op: nothing happens
        step("ex0_t0", 0, 0, 1, 4'd0, 0, 6'h00, 0, 0);
        step("ex0_t1", 0, 0, 0, 4'd0, 0, 6'h00, 0, 0);
        step("clr",    0, 0, 0, 4'd0, 1, 6'h00, 0, 0);

        // Abort N=15 with asynchronous reset in the 5th stall cycle
        step("ab_t0", 0, 0, 1, 4'd15, 0, 6'h0F, 0, 0);
        step("ab_t1", 0, 0, 0, 4'd0,  0, 6'h0F, 1, 0);
        step("ab_t2", 0, 0, 0, 4'd0,  0, 6'h0F, 1, 0);
        step("ab_t3", 0, 0, 0, 4'd0,  0, 6'h0F, 1, 0);
        exStart_i = 1'b0; memAccess_i = 1'b0; stallReqId_i = 1'b0; perfClr_i = 1'b0;
        expect_now(6'h0F, 1, 0);
        #1;
        compare_pop("ab_t4");
        rst = 1'b0;
        exp_perf = '0;
        expect_now(6'h00, 0, 0);
        #1;
        compare_pop("ab_rst");
        @(negedge clk);
        rst = 1'b1;
        step("ab_p0", 0, 0, 0, 4'd0, 0, 6'h00, 0, 0);
        step("ab_p1", 0, 0, 0, 4'd0, 0, 6'h00, 0, 0);
        step("ab_p2", 0, 0, 0, 4'd0, 0, 6'h00, 0, 0);

        // Saturation of the 4-bit perf counter, then clear while stalling
        for (int i = 0; i < 20; i++) begin
            step("sat", 1, 0, 0, 4'd0, 0, 6'h03, 0, 0);
        end
        step("satclr", 1, 0, 0, 4'd0, 1, 6'h03, 0, 0);
        step("aftclr", 1, 0, 0, 4'd0, 0, 6'h03, 0, 0);
        step("final",  0, 0, 0, 4'd0, 0, 6'h00, 0, 0);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed=%0d leftover expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
